// File: rtl/fir_pkg.sv
// ============================================================================
// fir_pkg : sample widths, Q15 limits and Q30->Q15 round/saturate helpers.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fir_pkg;

  localparam int SAMPLE_IN_W  = 32;
  localparam int SAMPLE_OUT_W = 16;
  localparam int Q_IN         = 30;
  localparam int Q_OUT        = 15;
  localparam int ROUND_W      = SAMPLE_IN_W + 1;

  localparam logic signed [SAMPLE_OUT_W-1:0] Q15_MAX = 16'sh7fff;
  localparam logic signed [SAMPLE_OUT_W-1:0] Q15_MIN = 16'sh8000;

  typedef logic signed [ROUND_W-1:0] round_t;

  typedef struct packed {
    logic                           sat;
    logic signed [SAMPLE_OUT_W-1:0] value;
  } q15_res_t;

  localparam round_t R_MAX = 33'sd32767;
  localparam round_t R_MIN = -33'sd32768;

  // Round half up: add half an output LSB before the arithmetic shift.
  function automatic round_t round_q(input logic signed [SAMPLE_IN_W-1:0] in,
                                     input int unsigned shift);
    round_t ext;
    round_t half;
    round_t sum;
    ext  = {in[SAMPLE_IN_W-1], in};
    half = (shift == 0) ? '0 : (round_t'(1) <<< (shift - 1));
    sum  = ext + half;
    return sum >>> shift;
  endfunction

  function automatic q15_res_t sat_q15(input round_t r);
    q15_res_t res;
    res.sat   = 1'b0;
    res.value = r[SAMPLE_OUT_W-1:0];
    if (r > R_MAX) begin
      res.sat   = 1'b1;
      res.value = Q15_MAX;
    end else if (r < R_MIN) begin
      res.sat   = 1'b1;
      res.value = Q15_MIN;
    end
    return res;
  endfunction

  function automatic q15_res_t round_sat_q15(input logic signed [SAMPLE_IN_W-1:0] in,
                                             input int unsigned shift);
    return sat_q15(round_q(in, shift));
  endfunction

endpackage

`default_nettype wire

// File: rtl/fir_output_requantizer_sync_fifo.sv
// ============================================================================
// sync_fifo : single-clock FIFO, registered storage, no combinational bypass.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (level == '0);
  assign full     = (level == (AW + 1)'(DEPTH));
  assign do_pop   = pop & ~empty;
  // A pop frees the slot in the same cycle, so a full FIFO can still accept.
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        level <= level + 1'b1;
      end else if (!do_push && do_pop) begin
        level <= level - 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fir_output_requantizer.sv
// ============================================================================
// fir_output_requantizer : skip warm-up, decimate, round/saturate Q30->Q15, FIFO out.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fir_output_requantizer
  import fir_pkg::*;
#(
  parameter int DECIM      = 4,
  parameter int SHIFT      = 15,
  parameter int SKIP       = 20,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [SAMPLE_IN_W-1:0]        in_sample,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [SAMPLE_OUT_W-1:0]       out_sample,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]              sat_count,
  output logic [CNT_W-1:0]              drop_count
);

  localparam int SKIP_W = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
  localparam int PH_W   = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [SKIP_W-1:0]       skip_cnt;
  logic [PH_W-1:0]         phase;
  logic                    warm;
  logic                    keep;

  logic                    s1_valid;
  round_t                  s1_round;
  q15_res_t                s1_sat_res;
  logic                    s2_valid;
  logic                    s2_sat;
  logic [SAMPLE_OUT_W-1:0] s2_sample;

  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    pop_ok;
  logic                    drop;

  assign warm = (skip_cnt == SKIP_W'(SKIP));
  assign keep = in_valid & warm & (phase == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skip_cnt <= '0;
      phase    <= '0;
    end else if (in_valid) begin
      if (!warm) begin
        skip_cnt <= skip_cnt + 1'b1;
      end else if (phase == PH_W'(DECIM - 1)) begin
        phase <= '0;
      end else begin
        phase <= phase + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_round <= '0;
    end else begin
      s1_valid <= keep;
      if (keep) begin
        s1_round <= round_q(in_sample, SHIFT);
      end
    end
  end

  assign s1_sat_res = sat_q15(s1_round);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      s2_sat    <= 1'b0;
      s2_sample <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sat    <= s1_sat_res.sat;
        s2_sample <= s1_sat_res.value;
      end
    end
  end

  // A stage-2 sample is lost only when the FIFO is full and nothing leaves it.
  assign pop_ok    = out_ready & ~fifo_empty;
  assign drop      = s2_valid & fifo_full & ~pop_ok;
  assign out_valid = ~fifo_empty;

  sync_fifo #(
    .WIDTH (SAMPLE_OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (s2_valid),
    .push_data (s2_sample),
    .pop       (out_ready),
    .pop_data  (out_sample),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_count  <= '0;
      drop_count <= '0;
    end else begin
      if (s2_valid && s2_sat && (sat_count != '1)) begin
        sat_count <= sat_count + 1'b1;
      end
      if (drop && (drop_count != '1)) begin
        drop_count <= drop_count + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fir_output_requantizer.sv
// ============================================================================
// tb_fir_output_requantizer : randomized stimulus against an arithmetic reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fir_output_requantizer;

  localparam int DECIM = 4;
  localparam int SKIP  = 20;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_sample = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_sample;
  logic [3:0]  fifo_level;
  logic [15:0] sat_count;
  logic [15:0] drop_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int          at;
    logic [15:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   m_skip  = 0;
  int   m_phase = 0;
  int   m_sat   = 0;

  fir_output_requantizer #(
    .DECIM      (DECIM),
    .SHIFT      (15),
    .SKIP       (SKIP),
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_sample  (in_sample),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sample (out_sample),
    .fifo_level (fifo_level),
    .sat_count  (sat_count),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  // Q30 -> Q15: floor((x + 0.5 LSB) / LSB), then clamp; returns {sat, value}.
  function automatic logic [16:0] ref_q15(input logic [31:0] x);
    longint v;
    longint q;
    v = longint'($signed(x)) + 64'sd16384;
    q = v / 64'sd32768;
    if (v < 0 && (v % 64'sd32768) != 0) q = q - 1;
    if (q > 32767)  return {1'b1, 16'h7fff};
    if (q < -32768) return {1'b1, 16'h8000};
    return {1'b0, q[15:0]};
  endfunction

  function automatic logic [31:0] rand_sample();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 2))
      0:       return r;
      1:       return {{3{r[31]}}, r[31:3]};
      default: return {{14{r[31]}}, r[31:14]};
    endcase
  endfunction

  task automatic model_reset();
    m_skip  = 0;
    m_phase = 0;
    m_sat   = 0;
    exp_q.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Apply one cycle of input and let the model record what must appear 3 cycles later.
  task automatic drive(input bit v, input logic [31:0] s);
    logic [16:0] r;
    exp_t        e;
    in_valid  = v;
    in_sample = s;
    if (v) begin
      if (m_skip < SKIP) begin
        m_skip++;
      end else begin
        if (m_phase == 0) begin
          r     = ref_q15(s);
          e.at  = cyc + 3;
          e.val = r[15:0];
          exp_q.push_back(e);
          if (r[16]) m_sat++;
        end
        m_phase = (m_phase + 1) % DECIM;
      end
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid  = 1'($urandom);
      in_sample = $urandom;
      out_ready = 1'($urandom);
      tick();
      total++;
      if (out_valid !== 1'b0 || fifo_level !== 4'd0 || sat_count !== 16'd0 ||
          drop_count !== 16'd0 || out_sample !== 16'd0) begin
        bad++;
        $display("FAIL reset cyc=%0d out_valid=%b level=%0d sat=%0d drop=%0d sample=%h, required all zero",
                 cyc, out_valid, fifo_level, sat_count, drop_count, out_sample);
      end
    end
    in_valid = 1'b0;
    rst      = 1'b0;
    model_reset();
  endtask

  task automatic test_warmup_decim();
    logic [15:0] seen[$];
    out_ready = 1'b1;
    for (int k = 0; k < 48; k++) begin
      if (k < 40) drive(1'b1, 32'(k) << 15);
      else        drive(1'b0, 32'h0);
      total++;
      if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
        if (out_valid !== 1'b1 || out_sample !== exp_q[0].val) begin
          bad++;
          $display("FAIL warmup_decim cyc=%0d out_valid=%b out_sample=%0d, required 1/%0d",
                   cyc, out_valid, out_sample, exp_q[0].val);
        end
        seen.push_back(out_sample);
        exp_q.delete(0);
      end else if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL warmup_decim cyc=%0d unexpected out_valid=%b out_sample=%0d, required 0",
                 cyc, out_valid, out_sample);
      end
    end
    total++;
    if (seen.size() != 5) begin
      bad++;
      $display("FAIL warmup_count got %0d outputs, required 5", seen.size());
    end
    for (int i = 0; i < seen.size() && i < 5; i++) begin
      total++;
      if (seen[i] !== 16'(20 + 4 * i)) begin
        bad++;
        $display("FAIL warmup_value[%0d] got %0d, required %0d", i, seen[i], 20 + 4 * i);
      end
    end
  endtask

  task automatic test_rounding();
    logic [31:0] vals [4];
    logic [15:0] want [4];
    logic [15:0] seen[$];
    int          idx;
    vals = '{32'h00004000, 32'hFFFFC000, 32'h00003FFF, 32'hFFFF8000};
    want = '{16'h0001, 16'h0000, 16'h0000, 16'hFFFF};
    idx  = 0;
    out_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if (idx < 4) begin
        if (m_phase == 0) begin
          drive(1'b1, vals[idx]);
          idx++;
        end else begin
          drive(1'b1, rand_sample());
        end
      end else begin
        drive(1'b0, 32'h0);
      end
      total++;
      if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
        if (out_valid !== 1'b1 || out_sample !== exp_q[0].val) begin
          bad++;
          $display("FAIL rounding cyc=%0d out_valid=%b out_sample=%h, required 1/%h",
                   cyc, out_valid, out_sample, exp_q[0].val);
        end
        seen.push_back(out_sample);
        exp_q.delete(0);
      end else if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL rounding cyc=%0d unexpected out_valid=%b out_sample=%h", cyc, out_valid, out_sample);
      end
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= seen.size() || seen[i] !== want[i]) begin
        bad++;
        $display("FAIL rounding_value[%0d] got %h, required %h", i,
                 (i < seen.size()) ? seen[i] : 16'hxxxx, want[i]);
      end
    end
    total++;
    if (sat_count !== 16'd0) begin
      bad++;
      $display("FAIL rounding_sat_count got %0d, required 0", sat_count);
    end
  endtask

  task automatic test_saturation();
    logic [31:0] vals [6];
    logic [15:0] want [6];
    int          idx;
    int          got;
    // Full-scale pair first, then values straddling the Q15 clamp thresholds.
    vals = '{32'h7FFFFFFF, 32'h80000000, 32'h3FFFBFFF, 32'h3FFFC000, 32'hC0000000, 32'hBFFFBFFF};
    want = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000};
    idx  = 0;
    got  = 0;
    out_ready = 1'b1;
    for (int n = 0; n < 60; n++) begin
      if (idx < 6 && !(idx == 2 && n < 20)) begin
        if (m_phase == 0) begin
          drive(1'b1, vals[idx]);
          idx++;
        end else begin
          drive(1'b1, rand_sample());
        end
      end else begin
        drive(1'b0, 32'h0);
      end
      total++;
      if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
        if (out_valid !== 1'b1 || out_sample !== exp_q[0].val ||
            (got < 6 && out_sample !== want[got])) begin
          bad++;
          $display("FAIL saturation cyc=%0d out_valid=%b out_sample=%h, required 1/%h",
                   cyc, out_valid, out_sample, exp_q[0].val);
        end
        got++;
        exp_q.delete(0);
      end else if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL saturation cyc=%0d unexpected out_valid=%b out_sample=%h", cyc, out_valid, out_sample);
      end
      if (n == 19) begin
        total++;
        if (sat_count !== 16'd2) begin
          bad++;
          $display("FAIL sat_count_pair got %0d, required 2", sat_count);
        end
      end
    end
    total++;
    if (sat_count !== 16'd4 || sat_count !== 16'(m_sat)) begin
      bad++;
      $display("FAIL sat_count_boundary got %0d, required 4", sat_count);
    end
  endtask

  task automatic test_random();
    out_ready = 1'b1;
    for (int n = 0; n < 306; n++) begin
      if (n < 300) drive($urandom_range(0, 3) != 0, rand_sample());
      else         drive(1'b0, 32'h0);
      total++;
      if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
        if (out_valid !== 1'b1 || out_sample !== exp_q[0].val) begin
          bad++;
          $display("FAIL random cyc=%0d out_valid=%b out_sample=%h, required 1/%h",
                   cyc, out_valid, out_sample, exp_q[0].val);
        end
        exp_q.delete(0);
      end else if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL random cyc=%0d unexpected out_valid=%b out_sample=%h", cyc, out_valid, out_sample);
      end
    end
    total++;
    if (sat_count !== 16'(m_sat) || drop_count !== 16'd0) begin
      bad++;
      $display("FAIL random_counters sat=%0d drop=%0d, required sat=%0d drop=0", sat_count, drop_count, m_sat);
    end
  endtask

  task automatic test_backpressure();
    exp_q.delete();
    out_ready = 1'b0;
    for (int n = 0; n < 40; n++) drive(1'b1, rand_sample());
    for (int n = 0; n < 3; n++)  drive(1'b0, 32'h0);
    total++;
    if (fifo_level !== 4'd8 || drop_count !== 16'(exp_q.size() - DEPTH) || drop_count !== 16'd2) begin
      bad++;
      $display("FAIL backpressure_fill level=%0d drop=%0d, required level=8 drop=2", fifo_level, drop_count);
    end
    for (int n = 0; n < 4; n++) begin
      total++;
      if (out_valid !== 1'b1 || out_sample !== exp_q[0].val || fifo_level !== 4'd8) begin
        bad++;
        $display("FAIL backpressure_hold cyc=%0d out_valid=%b out_sample=%h level=%0d, required 1/%h/8",
                 cyc, out_valid, out_sample, fifo_level, exp_q[0].val);
      end
      drive(1'b0, 32'h0);
    end
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_sample !== exp_q[i].val) begin
        bad++;
        $display("FAIL backpressure_drain[%0d] out_valid=%b out_sample=%h, required 1/%h",
                 i, out_valid, out_sample, exp_q[i].val);
      end
      drive(1'b0, 32'h0);
    end
    total++;
    if (out_valid !== 1'b0 || fifo_level !== 4'd0) begin
      bad++;
      $display("FAIL backpressure_empty out_valid=%b level=%0d, required 0/0", out_valid, fifo_level);
    end
    exp_q.delete();
  endtask

  task automatic test_reset_midstream();
    int got;
    got = 0;
    out_ready = 1'b0;
    for (int n = 0; n < 80 && fifo_level !== 4'd5; n++) drive(1'b1, rand_sample());
    total++;
    if (fifo_level !== 4'd5) begin
      bad++;
      $display("FAIL midreset_fill level=%0d, required 5", fifo_level);
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || fifo_level !== 4'd0 || sat_count !== 16'd0 || drop_count !== 16'd0) begin
      bad++;
      $display("FAIL midreset_async out_valid=%b level=%0d sat=%0d drop=%0d, required all zero",
               out_valid, fifo_level, sat_count, drop_count);
    end
    model_reset();
    tick();
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 27; n++) begin
      if (n < 21) drive(1'b1, rand_sample());
      else        drive(1'b0, 32'h0);
      total++;
      if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
        if (out_valid !== 1'b1 || out_sample !== exp_q[0].val) begin
          bad++;
          $display("FAIL midreset_rewarm cyc=%0d out_valid=%b out_sample=%h, required 1/%h",
                   cyc, out_valid, out_sample, exp_q[0].val);
        end
        got++;
        exp_q.delete(0);
      end else if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL midreset_rewarm cyc=%0d unexpected out_valid=%b out_sample=%h", cyc, out_valid, out_sample);
      end
    end
    total++;
    if (got != 1) begin
      bad++;
      $display("FAIL midreset_count got %0d outputs after 21 inputs, required 1", got);
    end
  endtask

  initial begin
    test_reset();
    test_warmup_decim();
    test_rounding();
    test_saturation();
    test_random();
    test_backpressure();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation exceeded time limit, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/fir_output_requantizer.md
Name: fir_output_requantizer

Overview:
Sits downstream of the transposed FIR low-pass filter and consumes its 32-bit full-precision output stream. It performs these steps in order:
- discards the filter warm-up samples;
- decimates by a fixed factor;
- rounds and saturates each kept sample back to 16-bit Q15;
- buffers results in a small FIFO behind a valid/ready output handshake.

It also keeps saturation and drop statistics for the control/status path.

Parameters:
DECIM, 4, decimation factor; 1 = keep every post-warm-up sample
SHIFT, 15, arithmetic right-shift applied to the Q30 input to return to Q15
SKIP, 20, number of valid input samples discarded after reset (filter fill)
FIFO_DEPTH, 8, output FIFO entries (power of two)
CNT_W, 16, width of the statistics counters

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  in_sample carries a new filter output this cycle (no upstream backpressure)
in_sample  input  32  signed Q30 filtered sample
out_valid  output  1  out_sample holds a valid result
out_ready  input  1  downstream accepts out_sample this cycle
out_sample  output  16  signed Q15 requantized sample
fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
sat_count  output  CNT_W  kept samples that saturated (sticks at all-ones)
drop_count  output  CNT_W  kept samples lost to a full FIFO (sticks at all-ones)

Behaviour:
Reset (asynchronous, active-high):
- out_valid=0, out_sample=0, fifo_level=0, sat_count=0, drop_count=0.
- Skip counter = 0, decimation phase = 0, pipeline valids cleared.
- Reset asserted mid-stream flushes the FIFO and the pipeline immediately.
- After release, the warm-up window restarts from zero.

Warm-up:
- The first SKIP cycles with in_valid=1 are discarded.
- in_valid=0 cycles do not advance the skip counter.

Decimation:
- After warm-up, each in_valid advances phase 0..DECIM-1, wrapping to 0.
- A sample is kept only when phase==0, so the first post-warm-up sample is kept.

Stage 1 (register), rounding:
- r = (sign-extend to 33 bits of in_sample + 2^(SHIFT-1)) >>> SHIFT.
- This is round-half-up, toward +inf on ties.

Stage 2 (register), saturation:
- Clamp r to [-32768, 32767].
- Set the sat flag when clamped.
- sat_count increments once per kept saturated sample.

FIFO write and latency:
- Stage-2 output is pushed into the FIFO.
- Latency: a kept input at cycle t gives out_valid=1 at cycle t+3 when the FIFO was empty and nothing is stalled.

FIFO full / drop rules:
- Push while full with no pop in the same cycle: the sample is dropped and drop_count increments.
- Push while full with a simultaneous pop (out_valid & out_ready): both succeed and the level is unchanged.

FIFO empty rules:
- Push while empty becomes visible on out_valid the next cycle.
- A push into an empty FIFO is never bypassed combinationally.

Output handshake:
- Transfer occurs on out_valid & out_ready.
- While out_valid=1 and out_ready=0, out_sample and out_valid hold stable.
- out_valid deasserts only after the last entry transfers.
- Output order is strictly FIFO.

Counters:
- Both statistics counters saturate at 2^CNT_W-1.
- They are cleared only by rst.

Decomposition:
Shared package fir_pkg holds:
- SAMPLE_IN_W=32, SAMPLE_OUT_W=16, Q_IN=30, Q_OUT=15;
- Q15 min/max constants;
- a pure function round_sat_q15(in, shift) returning {sat, value}, shared with the filter bench reference model.

One sub-module is natural: sync_fifo (parameterized width/depth, push/pop/full/empty/level, async active-high reset), instantiated once with width 16.

Test Plan:
1. Reset: assert rst for 3 cycles with random inputs -> out_valid=0, fifo_level=0, sat_count=0, drop_count=0 throughout.
2. Warm-up and decimation: out_ready=1; 40 consecutive valid samples in_sample=k<<15 for k=0..39 -> outputs exactly 20,24,28,32,36, each 3 cycles after its kept input.
3. Rounding (DECIM=1, after warm-up), in_sample -> out_sample, sat_count stays 0:
   - 0x00004000 -> 1
   - 0xFFFFC000 -> 0
   - 0x00003FFF -> 0
   - 0xFFFF8000 -> -1
4. Saturation: kept samples 0x7FFFFFFF and 0x80000000 -> 32767 and -32768; sat_count=2.
5. Backpressure: out_ready=0; 40 post-warm-up valid samples (DECIM=4, so 10 kept):
   - fifo_level=8, drop_count=2, out_sample stable;
   - then out_ready=1 -> the 8 oldest kept values are delivered in order on 8 consecutive cycles.
6. Reset mid-stream: async rst with fifo_level=5 -> out_valid and fifo_level drop to 0 without a clock edge; after release, the next 20 valid inputs produce no output.
